// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, default sizing and the BCD digit width.
`timescale 1ns/1ps
package bin_to_bcd_seq_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DIGITS  = 3;
  localparam int BCD_DIGIT_W = 4;

  // The encoding 2'b11 is unused; the converter recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake bundle between the ALU/operand side (master) and
// the converter (slave) that feeds the 7-segment display drivers.
`timescale 1ns/1ps
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic                  is_signed;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, is_signed, bin_in,
    input  busy, done, neg, bcd
  );

  modport slave (
    input  start, is_signed, bin_in,
    output busy, done, neg, bcd
  );

endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// One double-dabble digit correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
`timescale 1ns/1ps
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Pure combinational adjust; values 0..9 only ever reach here in use.
  always_comb begin
    dout = (din >= 4'd5) ? (din + 4'd3) : din;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). A start pulse
// captures the operand magnitude and sign; WIDTH shifts later the packed
// BCD digits and sign flag are published together with a one-cycle done.
`timescale 1ns/1ps
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic              clk,
  input  logic              rst_n,
  bin_to_bcd_seq_if.slave   bus
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    work_q, work_d;
  logic             neg_work_q, neg_work_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;
  logic [WIDTH-1:0] mag;
  logic             in_neg;

  // Per-digit add-3 correction applied to the working BCD register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Magnitude/sign of the incoming operand; the most negative value keeps
  // its unsigned reading (0x80 -> 128) since no overflow is reported.
  always_comb begin
    in_neg  = bus.is_signed & bus.bin_in[WIDTH-1];
    mag     = in_neg ? (~bus.bin_in + WIDTH'(1)) : bus.bin_in;
    shifted = {adj[BW-2:0], bin_q[WIDTH-1]};
  end

  // Next-state logic: FSM, shift registers, counter and output registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    work_d     = work_q;
    neg_work_d = neg_work_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          bin_d      = mag;
          work_d     = '0;
          cnt_d      = CW'(WIDTH);
          neg_work_d = in_neg;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        bin_d  = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted;
          neg_d   = neg_work_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous clear that aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      work_q     <= '0;
      neg_work_q <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      neg_work_q <= neg_work_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.neg  = neg_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD decoder using shift-and-add-3 (double dabble). It is the output-side inverse of the keypad input path, which turns decimal digits into binary. It takes the 8-bit operand or ALU result and produces packed BCD digits plus a sign flag for the 7-segment display drivers. It has a start/done handshake, so the display path loads a new value only when a conversion completes.

Parameters:
WIDTH, 8, binary input width in bits.
DIGITS, 3, BCD output digits; must satisfy DIGITS >= ceil(WIDTH*0.30103), 3 for WIDTH=8.

Ports:
Clock  input  1  system clock, rising-edge.
Clear  input  1  asynchronous active-low reset.
Start  input  1  request conversion; sampled on Clock rising edge.
Signed  input  1  1 = treat BinIn as two's complement; sampled with Start.
BinIn  input  WIDTH  value to convert; sampled with Start.
Busy  output  1  high while a conversion is in progress.
Done  output  1  one-cycle pulse; BCD/Neg valid and updated.
Neg  output  1  sign of the last converted value.
BCD  output  4*DIGITS  packed BCD result; digit 0 (ones) in bits [3:0].

Behaviour:
- Reset: Clear=0 forces state IDLE immediately; Busy=0, Done=0, Neg=0, BCD=0; working registers and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: Busy=0, Done=0.
  - If Start=1 at an edge: capture the magnitude into a WIDTH-bit shift register, clear the BCD working register, set the counter to WIDTH, capture the sign into a working neg flag, and go to SHIFT.
- Magnitude rule:
  - If Signed=1 and BinIn[WIDTH-1]=1: magnitude = (~BinIn + 1) mod 2^WIDTH, and neg=1.
  - Otherwise magnitude = BinIn and neg=0.
  - Most-negative value: 0x80 gives magnitude 0x80 = 128 (unsigned interpretation); no overflow flag.
- SHIFT: Busy=1.
  - Each edge: every working BCD digit >= 5 gets +3 (combinational, in parallel), then {bcd, bin} shifts left by 1 and the counter decrements.
  - When the counter reaches 0 on this edge (the WIDTH-th shift): copy the working BCD and neg into the BCD/Neg output registers, go to DONE.
- DONE: Busy=0, Done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: Start sampled at edge N gives BCD/Neg updated and Done=1 after edge N+WIDTH. Done falls at edge N+WIDTH+1. Earliest next accepted Start is edge N+WIDTH+2.
- Start while in SHIFT or DONE is ignored: no queuing, and the in-flight conversion is unaffected.
- BCD and Neg hold their last completed value between conversions. They never show partial values during SHIFT.
- Clear asserted mid-conversion aborts it: no Done pulse, outputs go to 0.
- Signed is ignored for the magnitude rule when BinIn[WIDTH-1]=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE.
  - default WIDTH and DIGITS constants.
  - the BCD digit width constant (4).
- Sub-module bcd_add3: combinational 4-bit digit adjust (in >= 5 ? in+3 : in). Instantiate DIGITS times via generate.
- The top holds the FSM, counter, shift registers and output registers.

Test Plan:
- Unsigned max: Clear pulse, then Start=1, Signed=0, BinIn=8'hFF for one cycle -> Busy high for 8 cycles; Done pulse at cycle 9 after Start; BCD=12'h255, Neg=0.
- Signed negatives:
  - Signed=1, BinIn=8'h80 -> BCD=12'h128, Neg=1.
  - Signed=1, BinIn=8'hFF -> BCD=12'h001, Neg=1.
  - Signed=1, BinIn=8'h7F -> BCD=12'h127, Neg=0.
- Zero and digit boundaries: BinIn=0 -> BCD=12'h000, Neg=0. BinIn=8'd9 -> 12'h009. BinIn=8'd10 -> 12'h010. BinIn=8'd100 -> 12'h100. Exhaustive sweep of 0..255 unsigned against a reference model.
- Start while busy:
  - Convert 8'd200; re-assert Start with BinIn=8'd7 at cycles 3 and 9 -> single Done, BCD=12'h200.
  - A Start at cycle 10 (IDLE) converts 7 -> BCD=12'h007.
- Hold behaviour: after converting 8'd42, keep Start=0 for 20 cycles -> BCD stays 12'h042, Done stays 0, Busy stays 0.
- Reset mid-operation:
  - Start with 8'd99; assert Clear asynchronously (between edges) at cycle 4 -> Busy, Done, Neg, BCD go to 0 immediately; no Done pulse.
  - After release, Start with 8'd5 -> BCD=12'h005 at the expected latency.
